mult59_accum: RTL and testbench

Downstream accumulate/round/saturate stage for the 59x59 signed pipelined multiplier. Tracks operand validity through a delay line matched to the multiplier's fixed 12-cycle latency, and accumulates ACC_LEN consecutive valid 118-bit products at full precision. Each completed sum is rounded and saturated to OUT_W bits and presented with a one-cycle valid pulse. Sits directly on the multiplier's `multout` bus and shares its `clk`/`en`.

---
 rtl/mult59_accum.sv | 149 ++++++++++++++
 tb/tb_mult59_accum.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult59_accum.sv
// mult59_accum: accumulate/round/saturate stage behind the 59x59 multiplier.
// Tracks product validity, sums ACC_LEN products, rounds half-up, clips.
module mult59_accum #(
  parameter int MULT_LAT   = 12,
  parameter int ACC_LEN    = 16,
  parameter int ACC_W      = 118 + $clog2(ACC_LEN),
  parameter int FRAC_SHIFT = 58,
  parameter int OUT_W      = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             op_valid,
  input  logic [117:0]     multout,
  input  logic             clr,
  output logic [OUT_W-1:0] acc_out,
  output logic             acc_valid,
  output logic             sat_flag,
  output logic             sat_sticky
);

  localparam int CNT_W = $clog2(ACC_LEN);
  localparam int RND_W = ACC_W + 1;

  localparam logic signed [RND_W-1:0] MAXV =
    {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] MINV =
    {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [MULT_LAT-1:0]       r_vpipe;
  logic [CNT_W-1:0]          r_count;
  logic signed [ACC_W-1:0]   r_acc;
  logic signed [ACC_W-1:0]   r_sum;
  logic signed [RND_W-1:0]   r_rnd;
  logic                      r_done1;
  logic                      r_done2;

  logic                      w_tail;
  logic                      w_wrap;
  logic signed [ACC_W-1:0]   w_prod;
  logic signed [ACC_W-1:0]   w_acc_nxt;
  logic signed [RND_W-1:0]   w_sum_ext;
  logic signed [RND_W-1:0]   w_rnd_add;
  logic signed [RND_W-1:0]   w_rnd;
  logic                      w_hi;
  logic                      w_lo;
  logic [OUT_W-1:0]          w_sat_val;

  assign w_tail    = r_vpipe[MULT_LAT-1];
  assign w_wrap    = w_tail && (r_count == CNT_W'(ACC_LEN - 1));
  assign w_prod    = {{(ACC_W-118){multout[117]}}, multout};
  assign w_acc_nxt = (r_count == '0) ? w_prod : r_acc + w_prod;

  // One extra bit ahead of the rounding add so the bias can never wrap.
  assign w_sum_ext = {r_sum[ACC_W-1], r_sum};
  assign w_rnd_add = w_sum_ext + (RND_W'(1) << (FRAC_SHIFT - 1));
  assign w_rnd     = w_rnd_add >>> FRAC_SHIFT;

  assign w_hi = r_rnd > MAXV;
  assign w_lo = r_rnd < MINV;

  // Clip the rounded sum into the signed output range.
  always_comb begin
    w_sat_val = r_rnd[OUT_W-1:0];
    if (w_hi) begin
      w_sat_val = {1'b0, {(OUT_W-1){1'b1}}};
    end else if (w_lo) begin
      w_sat_val = {1'b1, {(OUT_W-1){1'b0}}};
    end
  end

  // Validity delay line matched to the multiplier latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vpipe <= '0;
    end else if (en) begin
      if (clr) begin
        r_vpipe <= '0;
      end else begin
        r_vpipe <= (r_vpipe << 1) | MULT_LAT'(op_valid);
      end
    end
  end

  // Full-precision accumulation; the final product goes straight to r_sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_done1 <= 1'b0;
    end else if (en) begin
      if (clr) begin
        r_count <= '0;
        r_acc   <= '0;
        r_done1 <= 1'b0;
      end else begin
        r_done1 <= w_wrap;
        if (w_tail) begin
          r_acc   <= w_acc_nxt;
          r_count <= r_count + CNT_W'(1);
        end
        if (w_wrap) begin
          r_sum <= w_acc_nxt;
        end
      end
    end
  end

  // Round-half-up stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rnd   <= '0;
      r_done2 <= 1'b0;
    end else if (en) begin
      if (clr) begin
        r_done2 <= 1'b0;
      end else begin
        r_done2 <= r_done1;
        if (r_done1) begin
          r_rnd <= w_rnd;
        end
      end
    end
  end

  // Saturated output register, one-cycle valid pulse and sticky flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out    <= '0;
      acc_valid  <= 1'b0;
      sat_flag   <= 1'b0;
      sat_sticky <= 1'b0;
    end else if (!en) begin
      acc_valid <= 1'b0;
    end else if (clr) begin
      acc_valid  <= 1'b0;
      sat_sticky <= 1'b0;
    end else begin
      acc_valid <= r_done2;
      if (r_done2) begin
        acc_out    <= w_sat_val;
        sat_flag   <= w_hi | w_lo;
        sat_sticky <= sat_sticky | w_hi | w_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult59_accum.sv
// tb_mult59_accum: directed and random checks of mult59_accum
// against a sum-of-products reference model.
module tb_mult59_accum;

  localparam int MULT_LAT = 12;
  localparam int OUT_W    = 48;
  localparam longint MAXO = (64'sd1 <<< (OUT_W - 1)) - 1;
  localparam longint MINO = -(64'sd1 <<< (OUT_W - 1));

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic               op_valid;
  logic               clr;
  logic [117:0]       multout;
  logic [OUT_W-1:0]   acc_out;
  logic               acc_valid;
  logic               sat_flag;
  logic               sat_sticky;

  logic signed [117:0] prod_in;
  logic [117:0]        mpipe [MULT_LAT];

  mult59_accum dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .op_valid  (op_valid),
    .multout   (multout),
    .clr       (clr),
    .acc_out   (acc_out),
    .acc_valid (acc_valid),
    .sat_flag  (sat_flag),
    .sat_sticky(sat_sticky)
  );

  always #5 clk = ~clk;

  // Multiplier stand-in: fixed latency, shares en, has no reset.
  always @(posedge clk) begin
    if (en) begin
      for (int i = MULT_LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
      mpipe[0] <= prod_in;
    end
  end
  assign multout = mpipe[MULT_LAT-1];

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int gedge    = 0;

  // Reference model state
  logic signed [130:0] m_part;
  int                  m_cnt;
  logic                m_sticky;
  longint              e_out[$];
  logic                e_sat[$];
  logic                e_stk[$];
  int                  e_edge[$];

  int                  p_cyc[$];
  longint              p_out[$];
  logic                p_sat[$];

  longint prev_out;
  logic   prev_stk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_part   = '0;
    m_cnt    = 0;
    m_sticky = 1'b0;
  endtask

  task automatic model_push(input logic signed [117:0] p, input int edge_i);
    logic signed [130:0] r;
    longint o;
    logic   s;
    m_part = m_part + p;
    m_cnt++;
    if (m_cnt == 16) begin
      r = (m_part + (131'sd1 <<< 57)) >>> 58;
      if (r > MAXO) begin
        o = MAXO; s = 1'b1;
      end else if (r < MINO) begin
        o = MINO; s = 1'b1;
      end else begin
        o = longint'(r); s = 1'b0;
      end
      m_sticky = m_sticky | s;
      e_out.push_back(o);
      e_sat.push_back(s);
      e_stk.push_back(m_sticky);
      e_edge.push_back(edge_i + MULT_LAT + 2);
      m_part = '0;
      m_cnt  = 0;
    end
  endtask

  task automatic step(input logic v, input logic signed [117:0] p,
                      input logic e, input logic c);
    longint o;
    @(negedge clk);
    op_valid = v;
    prod_in  = p;
    en       = e;
    clr      = c;
    @(posedge clk);
    #1;
    cyc++;
    o = longint'($signed(acc_out));
    if (e) begin
      gedge++;
      if (c) model_clear();
      else if (v) model_push(p, gedge);
    end else begin
      chk("stall_valid", longint'(acc_valid), 0);
      chk("stall_out", o, prev_out);
      chk("stall_sticky", longint'(sat_sticky), longint'(prev_stk));
    end
    if (acc_valid) begin
      p_cyc.push_back(cyc);
      p_out.push_back(o);
      p_sat.push_back(sat_flag);
      chk("pulse_expected", longint'(e_out.size() > 0), 1);
      if (e_out.size() > 0) begin
        chk("model_out", o, e_out.pop_front());
        chk("model_sat", longint'(sat_flag), longint'(e_sat.pop_front()));
        chk("model_sticky", longint'(sat_sticky), longint'(e_stk.pop_front()));
        chk("model_edge", longint'(gedge), longint'(e_edge.pop_front()));
      end
    end
    prev_out = o;
    prev_stk = sat_sticky;
  endtask

  task automatic run(input int n, input logic signed [117:0] p);
    for (int i = 0; i < n; i++) step(1'b1, p, 1'b1, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic clear_pulses();
    p_cyc.delete();
    p_out.delete();
    p_sat.delete();
  endtask

  logic signed [117:0] P58;
  logic signed [117:0] PH;
  logic signed [117:0] PBIG;
  logic signed [117:0] PNEG;
  logic signed [117:0] rp;
  longint              lt;
  int                  c0;
  int                  clast;

  initial begin
    P58  = 118'sd1 <<< 58;
    PH   = P58 + (118'sd1 <<< 53);
    PBIG = 118'sd1 <<< 116;
    PNEG = -(118'sd1 <<< 116) + P58;
    model_clear();
    rst = 1'b1; en = 1'b0; op_valid = 1'b0; clr = 1'b0; prod_in = '0;
    #1;
    chk("rst_out", longint'($signed(acc_out)), 0);
    chk("rst_valid", longint'(acc_valid), 0);
    chk("rst_sat", longint'(sat_flag), 0);
    chk("rst_sticky", longint'(sat_sticky), 0);
    prev_out = 0;
    prev_stk = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Two back-to-back sums of 2^58 products
    clear_pulses();
    c0 = cyc + 1;
    run(32, P58);
    idle(20);
    chk("t1_npulse", p_cyc.size(), 2);
    if (p_cyc.size() == 2) begin
      chk("t1_edge0", p_cyc[0] - c0, 29);
      chk("t1_edge1", p_cyc[1] - c0, 45);
      chk("t1_out0", p_out[0], 16);
      chk("t1_out1", p_out[1], 16);
      chk("t1_sat0", longint'(p_sat[0]), 0);
    end

    // Half-up rounding at +16.5 and -16.5
    clear_pulses();
    run(16, PH);
    run(16, -PH);
    idle(20);
    chk("t2_npulse", p_cyc.size(), 2);
    if (p_cyc.size() == 2) begin
      chk("t2_pos", p_out[0], 17);
      chk("t2_neg", p_out[1], -16);
    end

    // Five stalled cycles in the middle of a stream
    clear_pulses();
    c0 = cyc + 1;
    run(8, P58);
    for (int i = 0; i < 5; i++) step(1'b1, P58, 1'b0, 1'b0);
    run(8, P58);
    idle(20);
    chk("t3_npulse", p_cyc.size(), 1);
    if (p_cyc.size() == 1) begin
      chk("t3_edge", p_cyc[0] - c0, 34);
      chk("t3_out", p_out[0], 16);
    end

    // Saturation both ways, then a clean sum keeps the sticky bit
    clear_pulses();
    run(16, PBIG);
    run(16, PNEG);
    run(16, P58);
    idle(20);
    chk("t4_npulse", p_cyc.size(), 3);
    if (p_cyc.size() == 3) begin
      chk("t4_max", p_out[0], MAXO);
      chk("t4_maxsat", longint'(p_sat[0]), 1);
      chk("t4_min", p_out[1], MINO);
      chk("t4_minsat", longint'(p_sat[1]), 1);
      chk("t4_clean", p_out[2], 16);
      chk("t4_cleansat", longint'(p_sat[2]), 0);
    end
    chk("t4_sticky", longint'(sat_sticky), 1);

    // Sparse partial sum dropped by clr landing on the 7th tail
    clear_pulses();
    for (int i = 0; i < 13; i++) step(i % 2 == 0, P58, 1'b1, 1'b0);
    idle(11);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("t5_sticky_clr", longint'(sat_sticky), 0);
    chk("t5_out_hold", longint'($signed(acc_out)), 16);
    run(16, P58);
    idle(20);
    chk("t5_npulse", p_cyc.size(), 1);
    if (p_cyc.size() == 1) chk("t5_out", p_out[0], 16);

    // Asynchronous reset mid-clock after 10 products
    run(16, PBIG);
    idle(20);
    clear_pulses();
    run(10, P58);
    #2;
    rst = 1'b1;
    en = 1'b0;
    op_valid = 1'b0;
    #1;
    chk("t6_rst_out", longint'($signed(acc_out)), 0);
    chk("t6_rst_sat", longint'(sat_flag), 0);
    chk("t6_rst_sticky", longint'(sat_sticky), 0);
    chk("t6_rst_valid", longint'(acc_valid), 0);
    model_clear();
    prev_out = 0;
    prev_stk = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run(16, P58);
    clast = cyc;
    idle(20);
    chk("t6_npulse", p_cyc.size(), 1);
    if (p_cyc.size() == 1) begin
      chk("t6_lat", p_cyc[0] - clast, 14);
      chk("t6_out", p_out[0], 16);
    end

    // Random products, gaps and stalls
    for (int i = 0; i < 160; i++) begin
      lt = longint'({$urandom, $urandom});
      rp = lt;
      if ($urandom_range(0, 7) == 0) rp = rp <<< 50;
      else rp = rp <<< $urandom_range(0, 12);
      step($urandom_range(0, 3) != 0, rp, $urandom_range(0, 7) != 0, 1'b0);
    end
    idle(30);
    chk("end_pending", e_out.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
